// File: rtl/ip_hdr_checksum_check.sv
// Receive-side IPv4 header checker: sums header words, verifies the ones-complement checksum,
// flags version/IHL errors. Define IP_CHECK_FIELDS_EN to capture total length, protocol and addresses.
module ip_hdr_checksum_check #(
  parameter int IP_VER_EXP = 4,
  parameter int ACC_W      = 21
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_sof,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        chk_done,
  output logic        chk_ok,
  output logic        hdr_err,
  output logic        busy,
  output logic [15:0] ip_total_len,
  output logic [7:0]  ip_protocol,
  output logic [31:0] src_ip,
  output logic [31:0] dst_ip
);

  typedef enum logic [1:0] {IDLE, HDR, FOLD, DONE} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [5:0]       byte_cnt_q, byte_cnt_d;
  logic [3:0]       ihl_q, ihl_d;
  logic [7:0]       hi_q, hi_d;
  logic             chk_done_q, chk_done_d;
  logic             chk_ok_q, chk_ok_d;
  logic             hdr_err_q, hdr_err_d;

  logic             sof;
  logic             bad_start;
  logic             last_byte;
  logic [15:0]      word;
  logic [16:0]      s1;
  logic [15:0]      s2;

  always_comb begin
    sof       = rx_valid & rx_sof;
    bad_start = (rx_data[7:4] != 4'(IP_VER_EXP)) || (rx_data[3:0] < 4'd5);
    last_byte = (byte_cnt_q == ({ihl_q, 2'b00} - 6'd1));
    word      = {hi_q, rx_data};
    // Two-step end-around-carry fold; the second add cannot carry out again.
    s1        = {1'b0, acc_q[15:0]} + 17'(acc_q[ACC_W-1:16]);
    s2        = s1[15:0] + {15'd0, s1[16]};

    state_d    = state_q;
    acc_d      = acc_q;
    byte_cnt_d = byte_cnt_q;
    ihl_d      = ihl_q;
    hi_d       = hi_q;
    chk_done_d = 1'b0;
    chk_ok_d   = chk_ok_q;
    hdr_err_d  = hdr_err_q;

    case (state_q)
      IDLE, HDR: begin
        // A new sof in HDR silently abandons the header in progress.
        if (sof) begin
          ihl_d      = rx_data[3:0];
          byte_cnt_d = 6'd1;
          acc_d      = '0;
          hi_d       = rx_data;
          if (bad_start) begin
            state_d    = DONE;
            chk_done_d = 1'b1;
            hdr_err_d  = 1'b1;
            chk_ok_d   = 1'b0;
          end else begin
            state_d = HDR;
          end
        end else if (state_q == HDR && rx_valid) begin
          byte_cnt_d = byte_cnt_q + 6'd1;
          if (!byte_cnt_q[0]) begin
            hi_d = rx_data;
          end else begin
            acc_d = acc_q + {{(ACC_W-16){1'b0}}, word};
            if (last_byte) state_d = FOLD;
          end
        end
      end
      FOLD: begin
        state_d    = DONE;
        chk_done_d = 1'b1;
        chk_ok_d   = (s2 == 16'hFFFF);
        hdr_err_d  = 1'b0;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      byte_cnt_q <= '0;
      ihl_q      <= '0;
      hi_q       <= '0;
      chk_done_q <= 1'b0;
      chk_ok_q   <= 1'b0;
      hdr_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      byte_cnt_q <= byte_cnt_d;
      ihl_q      <= ihl_d;
      hi_q       <= hi_d;
      chk_done_q <= chk_done_d;
      chk_ok_q   <= chk_ok_d;
      hdr_err_q  <= hdr_err_d;
    end
  end

  assign chk_done = chk_done_q;
  assign chk_ok   = chk_ok_q;
  assign hdr_err  = hdr_err_q;
  assign busy     = (state_q != IDLE);

`ifdef IP_CHECK_FIELDS_EN
  logic [15:0] tl_w_q, tl_w_d, tl_q, tl_d;
  logic [7:0]  pr_w_q, pr_w_d, pr_q, pr_d;
  logic [31:0] src_w_q, src_w_d, src_q, src_d;
  logic [31:0] dst_w_q, dst_w_d, dst_q, dst_d;

  // Working copies fill as bytes arrive; outputs move only on a completed header.
  always_comb begin
    tl_w_d  = tl_w_q;
    pr_w_d  = pr_w_q;
    src_w_d = src_w_q;
    dst_w_d = dst_w_q;
    tl_d    = tl_q;
    pr_d    = pr_q;
    src_d   = src_q;
    dst_d   = dst_q;
    if (state_q == HDR && rx_valid && !rx_sof) begin
      case (byte_cnt_q)
        6'd2:    tl_w_d[15:8]   = rx_data;
        6'd3:    tl_w_d[7:0]    = rx_data;
        6'd9:    pr_w_d         = rx_data;
        6'd12:   src_w_d[31:24] = rx_data;
        6'd13:   src_w_d[23:16] = rx_data;
        6'd14:   src_w_d[15:8]  = rx_data;
        6'd15:   src_w_d[7:0]   = rx_data;
        6'd16:   dst_w_d[31:24] = rx_data;
        6'd17:   dst_w_d[23:16] = rx_data;
        6'd18:   dst_w_d[15:8]  = rx_data;
        6'd19:   dst_w_d[7:0]   = rx_data;
        default: ;
      endcase
    end
    if (state_q == FOLD) begin
      tl_d  = tl_w_q;
      pr_d  = pr_w_q;
      src_d = src_w_q;
      dst_d = dst_w_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tl_w_q  <= '0;
      pr_w_q  <= '0;
      src_w_q <= '0;
      dst_w_q <= '0;
      tl_q    <= '0;
      pr_q    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
    end else begin
      tl_w_q  <= tl_w_d;
      pr_w_q  <= pr_w_d;
      src_w_q <= src_w_d;
      dst_w_q <= dst_w_d;
      tl_q    <= tl_d;
      pr_q    <= pr_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
    end
  end

  assign ip_total_len = tl_q;
  assign ip_protocol  = pr_q;
  assign src_ip       = src_q;
  assign dst_ip       = dst_q;
`else
  assign ip_total_len = '0;
  assign ip_protocol  = '0;
  assign src_ip       = '0;
  assign dst_ip       = '0;
`endif

endmodule

// File: tb/tb_ip_hdr_checksum_check.sv
// Bench for ip_hdr_checksum_check: directed header cases plus random headers checked
// against an RFC-style ones-complement reference model.
module tb_ip_hdr_checksum_check;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic        ok;
    logic        err;
    logic [15:0] tl;
    logic [7:0]  pr;
    logic [31:0] src;
    logic [31:0] dst;
  } res_t;

`ifdef IP_CHECK_FIELDS_EN
  localparam bit FIELDS = 1'b1;
`else
  localparam bit FIELDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_sof;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        chk_done;
  logic        chk_ok;
  logic        hdr_err;
  logic        busy;
  logic [15:0] ip_total_len;
  logic [7:0]  ip_protocol;
  logic [31:0] src_ip;
  logic [31:0] dst_ip;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (chk_done) done_cnt <= done_cnt + 1;

  ip_hdr_checksum_check dut (
    .clk          (clk),
    .reset        (reset),
    .rx_sof       (rx_sof),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .chk_done     (chk_done),
    .chk_ok       (chk_ok),
    .hdr_err      (hdr_err),
    .busy         (busy),
    .ip_total_len (ip_total_len),
    .ip_protocol  (ip_protocol),
    .src_ip       (src_ip),
    .dst_ip       (dst_ip)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] d);
    rx_valid = v;
    rx_sof   = s;
    rx_data  = d;
    @(posedge clk);
    #1;
  endtask

  // Reference: sum all header words in a wide integer, fold until no carry remains.
  function automatic res_t model(input bq_t h);
    res_t        r;
    int unsigned s;
    int          ihl;
    r   = '0;
    ihl = int'(h[0][3:0]);
    if (h[0][7:4] != 4'd4 || ihl < 5) begin
      r.err = 1'b1;
      return r;
    end
    s = 0;
    for (int i = 0; i < ihl * 2; i++) s += 32'({h[2*i], h[2*i+1]});
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    r.ok  = (s == 32'hFFFF);
    r.tl  = {h[2], h[3]};
    r.pr  = h[9];
    r.src = {h[12], h[13], h[14], h[15]};
    r.dst = {h[16], h[17], h[18], h[19]};
    return r;
  endfunction

  function automatic logic [15:0] csum_of(input bq_t h);
    int unsigned s;
    s = 0;
    for (int i = 0; i < h.size() / 2; i++)
      if (i != 5) s += 32'({h[2*i], h[2*i+1]});
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    return ~s[15:0];
  endfunction

  function automatic bq_t rand_hdr(input int ihl);
    bq_t         h;
    logic [15:0] c;
    h = {};
    for (int i = 0; i < ihl * 4; i++) h.push_back(8'($urandom));
    h[0]  = {4'd4, 4'(ihl)};
    c     = csum_of(h);
    h[10] = c[15:8];
    h[11] = c[7:0];
    return h;
  endfunction

  // mode 0: no stalls; 1: 3 idle cycles after every 4th byte; 2: random stalls
  task automatic send_hdr(input bq_t h, input int mode);
    for (int i = 0; i < h.size(); i++) begin
      drive(1'b1, i == 0, h[i]);
      if (i != h.size() - 1) begin
        if (mode == 1 && (i % 4) == 3) repeat (3) drive(1'b0, 1'b0, 8'($urandom));
        if (mode == 2 && $urandom_range(0, 3) == 0)
          repeat ($urandom_range(1, 3)) drive(1'b0, $urandom_range(0, 1) == 1, 8'($urandom));
      end
    end
    rx_valid = 1'b0;
    rx_sof   = 1'b0;
  endtask

  // Called just after the edge that accepted the last byte.
  task automatic expect_result(input string tag, input bq_t h);
    res_t r;
    int   d0;
    r  = model(h);
    d0 = done_cnt;
    chk({tag, "_fold_gap"}, 32'(chk_done), 32'(1'b0));
    drive(1'b0, 1'b0, 8'h00);
    chk({tag, "_done"}, 32'(chk_done), 32'(1'b1));
    chk({tag, "_ok"}, 32'(chk_ok), 32'(r.ok));
    chk({tag, "_err"}, 32'(hdr_err), 32'(r.err));
    chk({tag, "_busy_done"}, 32'(busy), 32'(1'b1));
    chk({tag, "_tl"}, 32'(ip_total_len), FIELDS ? 32'(r.tl) : 32'h0);
    chk({tag, "_pr"}, 32'(ip_protocol), FIELDS ? 32'(r.pr) : 32'h0);
    chk({tag, "_src"}, src_ip, FIELDS ? r.src : 32'h0);
    chk({tag, "_dst"}, dst_ip, FIELDS ? r.dst : 32'h0);
    drive(1'b0, 1'b0, 8'h00);
    chk({tag, "_pulse_end"}, 32'(chk_done), 32'(1'b0));
    chk({tag, "_ok_held"}, 32'(chk_ok), 32'(r.ok));
    chk({tag, "_busy_idle"}, 32'(busy), 32'(1'b0));
    chk({tag, "_pulses"}, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic bad_hdr(input string tag, input logic [7:0] first);
    int d0;
    d0 = done_cnt;
    drive(1'b1, 1'b1, first);
    chk({tag, "_done"}, 32'(chk_done), 32'(1'b1));
    chk({tag, "_err"}, 32'(hdr_err), 32'(1'b1));
    chk({tag, "_ok"}, 32'(chk_ok), 32'(1'b0));
    for (int i = 1; i < 20; i++) drive(1'b1, 1'b0, 8'($urandom));
    drive(1'b0, 1'b0, 8'h00);
    chk({tag, "_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'(1'b0));
    chk({tag, "_err_held"}, 32'(hdr_err), 32'(1'b1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t         t1, t2, t6, h;
    logic [15:0] c;
    int          d0;

    t1 = {8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
          8'hb8, 8'h61, 8'hc0, 8'ha8, 8'h00, 8'h01, 8'hc0, 8'ha8, 8'h00, 8'hc7};

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_sof   = 1'b0;
    rx_data  = 8'h00;
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    chk("rst_done", 32'(chk_done), 32'h0);
    chk("rst_ok", 32'(chk_ok), 32'h0);
    chk("rst_err", 32'(hdr_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_src", src_ip, 32'h0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00);

    // Test 1: reference header, explicit literal field values as well as the model
    send_hdr(t1, 0);
    expect_result("t1", t1);
    chk("t1_ok_lit", 32'(chk_ok), 32'h1);
    chk("t1_src_lit", src_ip, FIELDS ? 32'hC0A80001 : 32'h0);
    chk("t1_dst_lit", dst_ip, FIELDS ? 32'hC0A800C7 : 32'h0);
    chk("t1_pr_lit", 32'(ip_protocol), FIELDS ? 32'h11 : 32'h0);
    chk("t1_tl_lit", 32'(ip_total_len), FIELDS ? 32'h73 : 32'h0);

    // Test 2: corrupted checksum
    t2     = t1;
    t2[11] = 8'h62;
    send_hdr(t2, 0);
    expect_result("t2", t2);
    chk("t2_ok_lit", 32'(chk_ok), 32'h0);

    // Test 3: IHL too small, then wrong version
    bad_hdr("t3_ihl4", 8'h44);
    bad_hdr("t3_ver6", 8'h65);

    // Test 4: stalls, then IHL=6 with zero options
    send_hdr(t1, 1);
    expect_result("t4_stall", t1);
    chk("t4_err_cleared", 32'(hdr_err), 32'h0);
    t6    = t1;
    t6[0] = 8'h46;
    for (int i = 0; i < 4; i++) t6.push_back(8'h00);
    c      = csum_of(t6);
    t6[10] = c[15:8];
    t6[11] = c[7:0];
    send_hdr(t6, 0);
    expect_result("t4_ihl6", t6);
    chk("t4_ihl6_ok_lit", 32'(chk_ok), 32'h1);

    // Test 5: abort after 7 bytes by a new sof
    d0 = done_cnt;
    for (int i = 0; i < 7; i++) drive(1'b1, i == 0, t2[i]);
    send_hdr(t1, 0);
    expect_result("t5", t1);
    chk("t5_single_done", 32'(done_cnt - d0), 32'd1);

    // Test 6: reset in the middle of a header
    d0 = done_cnt;
    for (int i = 0; i < 10; i++) drive(1'b1, i == 0, t1[i]);
    reset = 1'b1;
    #1;
    chk("t6_rst_ok", 32'(chk_ok), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_done", 32'(chk_done), 32'h0);
    chk("t6_rst_src", src_ip, 32'h0);
    chk("t6_rst_tl", 32'(ip_total_len), 32'h0);
    repeat (2) drive(1'b1, 1'b0, 8'($urandom));
    reset = 1'b0;
    repeat (12) drive(1'b1, 1'b0, 8'($urandom));
    drive(1'b0, 1'b0, 8'h00);
    chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
    send_hdr(t1, 0);
    expect_result("t6_after", t1);

    // Random headers, random IHL, stalls and occasional corruption
    for (int n = 0; n < 24; n++) begin
      h = rand_hdr($urandom_range(5, 15));
      if ($urandom_range(0, 2) == 0)
        h[$urandom_range(1, h.size() - 1)] ^= 8'($urandom_range(1, 255));
      send_hdr(h, (n % 3 == 0) ? 0 : 2);
      expect_result($sformatf("rnd%0d", n), h);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
